// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline M/W stages.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mux2x1.sv
// Generic 2:1 multiplexer, sel=1 picks d1.
module mux2x1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/mem_wb_stage.sv
// M-stage data-memory access over a req/ack handshake with timeout, plus the
// MEM/WB register. StallM holds the upstream pipeline while the access runs.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic        AlignErr,
    output logic        BusErr
);

    memState_t        state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic             lRegWrite, lMemtoReg;
    logic [4:0]       lWriteReg;
    logic [31:0]      lAluOut, rdataCap, doneResult;
    logic             memOp, aligned, timeout;

    assign memOp   = MemtoRegM | MemWriteM;
    assign aligned = isWordAligned(ALUOutM);
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stateNext = state;
        StallM    = 1'b0;
        case (state)
            IDLE: if (memOp && aligned) begin
                StallM    = 1'b1;
                stateNext = BUSY;
            end
            BUSY: begin
                StallM = 1'b1;
                if (dmem_ack || timeout) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    mux2x1 #(.W(32)) u_resMux (
        .d0 (lAluOut),
        .d1 (rdataCap),
        .sel(lMemtoReg),
        .y  (doneResult)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            lRegWrite  <= 1'b0;
            lMemtoReg  <= 1'b0;
            lWriteReg  <= '0;
            lAluOut    <= '0;
            rdataCap   <= '0;
            RegWriteW  <= 1'b0;
            WriteRegW  <= '0;
            ResultW    <= '0;
            AlignErr   <= 1'b0;
            BusErr     <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (!memOp) begin
                        RegWriteW <= RegWriteM;
                        WriteRegW <= WriteRegM;
                        ResultW   <= ALUOutM;
                    end else if (!aligned) begin
                        // Misaligned access is squashed without touching the bus
                        AlignErr  <= 1'b1;
                        RegWriteW <= 1'b0;
                    end else begin
                        dmem_addr  <= ALUOutM;
                        dmem_wdata <= WriteDataM;
                        dmem_we    <= MemWriteM & ~MemtoRegM;
                        dmem_req   <= 1'b1;
                        cnt        <= '0;
                        lRegWrite  <= RegWriteM;
                        lMemtoReg  <= MemtoRegM;
                        lWriteReg  <= WriteRegM;
                        lAluOut    <= ALUOutM;
                        RegWriteW  <= 1'b0;
                    end
                end
                BUSY: begin
                    RegWriteW <= 1'b0;
                    cnt       <= cnt + CNT_W'(1);
                    if (dmem_ack) begin
                        rdataCap <= dmem_rdata;
                        dmem_req <= 1'b0;
                    end else if (timeout) begin
                        // Abandon the access: no write-back, known data
                        rdataCap  <= BUS_ERR_DATA;
                        lRegWrite <= 1'b0;
                        dmem_req  <= 1'b0;
                        BusErr    <= 1'b1;
                    end
                end
                DONE: begin
                    RegWriteW <= lRegWrite;
                    WriteRegW <= lWriteReg;
                    ResultW   <= doneResult;
                end
                default: ;
            endcase
        end
    end

endmodule
